// File: rtl/blur_stream_ctrl.sv
// Sequencing controller for the horizontal Gaussian blur: primes, streams and flushes each video line.
// Optional frame counter output enabled by defining BLUR_CTRL_FRAME_CNT_EN.
module blur_stream_ctrl #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480,
  parameter int TAPS    = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [3:0]  in_type,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        win_shift,
  output logic        win_flush,
  output logic        bypass,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        frame_err
`ifdef BLUR_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int HALF = (TAPS - 1) / 2;
  localparam logic [10:0] HALF_C = 11'(HALF);
  localparam logic [10:0] W_LAST = 11'(IMAGE_W - 1);
  localparam logic [10:0] H_LAST = 11'(IMAGE_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL,
    S_PRIME,
    S_STREAM,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] acc_q, acc_d;
  logic [10:0] emit_q, emit_d;
  logic [10:0] line_q, line_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        err_q, err_d;
  logic        eop_pend_q, eop_pend_d;
  logic        long_q, long_d;

  logic rdy, vld, sop, eop, shift, flush, byp, vid;
  logic is_stream, last_px, flush_last;

  assign is_stream  = (state_q == S_STREAM);
  assign last_px    = (acc_q == W_LAST) && (line_q == H_LAST);
  assign flush_last = ((emit_q + 11'd1) == acc_q);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    emit_d     = emit_q;
    line_d     = line_q;
    err_d      = err_q;
    eop_pend_d = eop_pend_q;
    long_d     = long_q;
    rdy        = 1'b0;
    vld        = 1'b0;
    sop        = 1'b0;
    eop        = 1'b0;
    shift      = 1'b0;
    flush      = 1'b0;
    byp        = 1'b0;
    vid        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (in_valid && in_sop) begin
          rdy = out_ready;
          vld = 1'b1;
          byp = 1'b1;
          sop = 1'b1;
          eop = in_eop && (in_type != 4'd0);
          if (out_ready) begin
            if (in_type == 4'd0) begin
              state_d    = S_PRIME;
              acc_d      = '0;
              emit_d     = '0;
              line_d     = '0;
              eop_pend_d = 1'b0;
              long_d     = 1'b0;
            end else if (!in_eop) begin
              state_d = S_CTRL;
            end
          end
        end
      end
      S_CTRL: begin
        rdy = out_ready;
        vld = in_valid;
        byp = 1'b1;
        eop = in_eop;
        if (in_valid && out_ready && in_eop)
          state_d = S_IDLE;
      end
      S_PRIME, S_STREAM: begin
        rdy = is_stream ? out_ready : 1'b1;
        vld = is_stream && in_valid;
        vid = vld;
        if (in_valid && rdy) begin
          shift = 1'b1;
          acc_d = acc_q + 11'd1;
          if (is_stream)
            emit_d = emit_q + 11'd1;
          if (in_sop)
            err_d = 1'b1;
          if (in_eop && !last_px) begin
            // Short frame: flush only what is still held in the window
            err_d = 1'b1;
            if (acc_d == emit_d) begin
              eop     = 1'b1;
              state_d = S_IDLE;
            end else begin
              eop_pend_d = 1'b1;
              state_d    = S_FLUSH;
            end
          end else if (acc_q == W_LAST) begin
            long_d  = last_px && !in_eop;
            state_d = S_FLUSH;
          end else if (!is_stream && acc_d == HALF_C) begin
            state_d = S_STREAM;
          end
        end
      end
      S_FLUSH: begin
        vld = 1'b1;
        vid = 1'b1;
        eop = flush_last && (eop_pend_q || line_q == H_LAST);
        if (out_ready) begin
          flush  = 1'b1;
          emit_d = emit_q + 11'd1;
          if (flush_last) begin
            if (eop_pend_q) begin
              state_d = S_IDLE;
            end else if (line_q == H_LAST) begin
              state_d = long_q ? S_DRAIN : S_IDLE;
            end else begin
              acc_d   = '0;
              emit_d  = '0;
              line_d  = line_q + 11'd1;
              state_d = S_PRIME;
            end
          end
        end
      end
      S_DRAIN: begin
        rdy   = 1'b1;
        err_d = 1'b1;
        if (in_valid && in_eop)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x_d = vid ? emit_q : x_q;
  assign y_d = vid ? line_q : y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      emit_q     <= '0;
      line_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      err_q      <= 1'b0;
      eop_pend_q <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      emit_q     <= emit_d;
      line_q     <= line_d;
      x_q        <= x_d;
      y_q        <= y_d;
      err_q      <= err_d;
      eop_pend_q <= eop_pend_d;
      long_q     <= long_d;
    end
  end

  // Combinational strobes are forced low while reset is held
  assign in_ready  = rdy & ~reset;
  assign out_valid = vld & ~reset;
  assign out_sop   = sop & ~reset;
  assign out_eop   = eop & ~reset;
  assign win_shift = shift & ~reset;
  assign win_flush = flush & ~reset;
  assign bypass    = byp & ~reset;
  assign x         = x_d;
  assign y         = y_d;
  assign frame_err = err_q;

`ifdef BLUR_CTRL_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fcnt_q <= '0;
    else if (vid && out_ready && eop)
      fcnt_q <= fcnt_q + 16'd1;
  end

  assign frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_blur_stream_ctrl.sv
// Directed bench for blur_stream_ctrl with IMAGE_W=16, IMAGE_H=2, TAPS=13.
module tb_blur_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [3:0]  in_type = 4'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_sop, out_eop;
  logic        win_shift, win_flush, bypass, frame_err;
  logic [10:0] x, y;
`ifdef BLUR_CTRL_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  blur_stream_ctrl #(.IMAGE_W(16), .IMAGE_H(2), .TAPS(13)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sop(in_sop),
    .in_eop(in_eop),
    .in_type(in_type),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .win_shift(win_shift),
    .win_flush(win_flush),
    .bypass(bypass),
    .x(x),
    .y(y),
    .frame_err(frame_err)
`ifdef BLUR_CTRL_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [10:0] ox[$];
  logic [10:0] oy[$];
  bit          osop[$];
  bit          oeop[$];
  bit          obyp[$];
  int shift_cnt, flush_cnt, silent_cnt, stream_obs, rdy_mis, vid_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        ox.push_back(x);
        oy.push_back(y);
        osop.push_back(out_sop);
        oeop.push_back(out_eop);
        obyp.push_back(bypass);
        if (!bypass) vid_cnt++;
      end
      if (win_shift) shift_cnt++;
      if (win_flush) flush_cnt++;
      if (in_valid && in_ready && !out_valid) silent_cnt++;
      if (out_valid && !bypass && !win_flush && in_valid) begin
        stream_obs++;
        if (in_ready !== out_ready) rdy_mis++;
      end
    end
  end

  task automatic clear_mon();
    ox.delete(); oy.delete(); osop.delete(); oeop.delete(); obyp.delete();
    shift_cnt = 0; flush_cnt = 0; silent_cnt = 0;
    stream_obs = 0; rdy_mis = 0; vid_cnt = 0;
  endtask

  // Expected video beat k (after the header) is x=k%16, y=k/16; eop only on beat n-1
  function automatic int seq_bad(input int n);
    int bad = 0;
    if (ox.size() != n + 1) bad++;
    for (int k = 0; k < n; k++) begin
      if (k + 1 >= ox.size()) bad++;
      else if (ox[k+1] != 11'(k % 16) || oy[k+1] != 11'(k / 16) ||
               obyp[k+1] || osop[k+1] || oeop[k+1] != (k == n - 1)) bad++;
    end
    return bad;
  endfunction

  // Sends header (type typ) then npix beats; eop on beat index eop_at
  task automatic run_frame(input logic [3:0] typ, input int npix,
                           input int eop_at, input bit toggle,
                           input int stop_vid);
    int  idx = 0;
    int  quiet = 0;
    bit  acc;
    bit  done = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 800 && !done; c++) begin
      in_valid = (idx <= npix);
      in_sop   = (idx == 0);
      in_type  = (idx == 0) ? typ : idx[3:0];
      in_eop   = (idx == eop_at) && (idx != 0);
      if (toggle) out_ready = (c % 2 == 0);
      @(negedge clk);
      acc   = in_valid && in_ready;
      quiet = (idx > npix && !out_valid) ? quiet + 1 : 0;
      @(posedge clk); #1;
      if (acc) idx++;
      if (stop_vid > 0 && vid_cnt >= stop_vid) done = 1;
      if (quiet >= 10) done = 1;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL run_frame timeout: sent %0d of %0d beats", idx, npix + 1);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_sop = 1'b1; in_type = 4'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_sop, out_eop, win_shift, win_flush,
         bypass, frame_err} !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {in_ready, out_valid, out_sop, out_eop, win_shift,
                win_flush, bypass, frame_err});
    end
    tests++;
    if ({x, y} !== 22'd0) begin
      fails++;
      $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", x, y);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_probe(input string tag);
    in_valid = 1'b1; in_sop = 1'b1; in_type = 4'hF; out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, bypass, out_sop, in_ready} !== 4'b1110) begin
      fails++;
      $display("FAIL %s idle_probe: v/byp/sop/rdy=%b want 1110",
               tag, {out_valid, bypass, out_sop, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_nominal();
    int b;
    clear_mon();
    run_frame(4'd0, 32, 32, 1'b0, 0);
    tests++;
    if (ox.size() < 1 || !(osop[0] && obyp[0])) begin
      fails++;
      $display("FAIL nominal_header: size=%0d want header with sop+bypass",
               ox.size());
    end
    b = seq_bad(32);
    tests++;
    if (b != 0) begin
      fails++;
      $display("FAIL nominal_seq: %0d bad beats of %0d outputs, want 0 of 33",
               b, ox.size());
    end
    tests++;
    if (ox.size() != 33 || ox[$] != 11'd15 || oy[$] != 11'd1 || !oeop[$]) begin
      fails++;
      $display("FAIL nominal_eop: last x=%0d y=%0d eop=%b want 15 1 1",
               ox[$], oy[$], oeop[$]);
    end
    tests++;
    if (silent_cnt != 12 || stream_obs != 20 || flush_cnt != 12) begin
      fails++;
      $display("FAIL nominal_phases: prime=%0d stream=%0d flush=%0d want 12 20 12",
               silent_cnt, stream_obs, flush_cnt);
    end
    tests++;
    if (shift_cnt != 32 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL nominal_shift_err: shift=%0d err=%b want 32 0",
               shift_cnt, frame_err);
    end
  endtask

  task automatic test_ctrl();
    clear_mon();
    run_frame(4'hF, 2, 2, 1'b0, 0);
    tests++;
    if (ox.size() != 3 || !(obyp[0] && obyp[1] && obyp[2])) begin
      fails++;
      $display("FAIL ctrl_count: outputs=%0d want 3 all bypass", ox.size());
    end
    tests++;
    if (ox.size() != 3 || {osop[0], osop[1], osop[2]} != 3'b100 ||
        {oeop[0], oeop[1], oeop[2]} != 3'b001) begin
      fails++;
      $display("FAIL ctrl_sop_eop: outputs=%0d want sop 100 eop 001",
               ox.size());
    end
    tests++;
    if (shift_cnt != 0) begin
      fails++;
      $display("FAIL ctrl_shift: win_shift count=%0d want 0", shift_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int b;
    clear_mon();
    run_frame(4'd0, 32, 32, 1'b1, 0);
    b = seq_bad(32);
    tests++;
    if (b != 0) begin
      fails++;
      $display("FAIL bp_seq: %0d bad beats of %0d outputs, want 0 of 33",
               b, ox.size());
    end
    tests++;
    if (rdy_mis != 0 || stream_obs < 20) begin
      fails++;
      $display("FAIL bp_ready: mismatches=%0d obs=%0d want 0 and >=20",
               rdy_mis, stream_obs);
    end
    tests++;
    if (flush_cnt != 12 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL bp_flush_err: flush=%0d err=%b want 12 0",
               flush_cnt, frame_err);
    end
  endtask

  task automatic test_short();
    int b;
    clear_mon();
    run_frame(4'd0, 20, 20, 1'b0, 0);
    b = seq_bad(20);
    tests++;
    if (b != 0) begin
      fails++;
      $display("FAIL short_seq: %0d bad beats of %0d outputs, want 0 of 21",
               b, ox.size());
    end
    tests++;
    if (flush_cnt != 10 || silent_cnt != 10) begin
      fails++;
      $display("FAIL short_flush: flush=%0d prime=%0d want 10 10",
               flush_cnt, silent_cnt);
    end
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL short_err: frame_err=%b want 1", frame_err);
    end
    idle_probe("short");
  endtask

  task automatic test_long();
    int b;
    clear_mon();
    run_frame(4'd0, 37, 37, 1'b0, 0);
    b = seq_bad(32);
    tests++;
    if (b != 0) begin
      fails++;
      $display("FAIL long_seq: %0d bad beats of %0d outputs, want 0 of 33",
               b, ox.size());
    end
    tests++;
    if (silent_cnt != 17 || shift_cnt != 32) begin
      fails++;
      $display("FAIL long_drain: silent=%0d shift=%0d want 17 32",
               silent_cnt, shift_cnt);
    end
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL long_err: frame_err=%b want 1", frame_err);
    end
    idle_probe("long");
  endtask

  task automatic test_reset_mid();
    int b;
    clear_mon();
    run_frame(4'd0, 32, 32, 1'b0, 9);
    tests++;
    if (ox.size() != 10 || ox[$] != 11'd8 || oy[$] != 11'd0) begin
      fails++;
      $display("FAIL mid_position: outputs=%0d x=%0d y=%0d want 10 8 0",
               ox.size(), ox[$], oy[$]);
    end
    in_valid = 1'b1; in_sop = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, out_sop, out_eop, win_shift, win_flush,
         bypass, frame_err} !== 8'd0 || {x, y} !== 22'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: ctl=%b x=%0d y=%0d want 0 0 0",
               {in_ready, out_valid, out_sop, out_eop, win_shift,
                win_flush, bypass, frame_err}, x, y);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    clear_mon();
    run_frame(4'd0, 32, 32, 1'b0, 0);
    b = seq_bad(32);
    tests++;
    if (b != 0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL mid_rerun: %0d bad beats, outputs=%0d err=%b want 0 33 0",
               b, ox.size(), frame_err);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_nominal();
    test_ctrl();
    test_back_to_back();
    test_short();
    test_long();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/blur_stream_ctrl.md
Name: blur_stream_ctrl

Overview:
- Sequencing controller for the 13-tap horizontal Gaussian blur datapath in the video pipeline.
- Terminates the Avalon-ST video valid/ready handshake and classifies packets from the sop word.
- Per video line: primes the blur window, streams pixels, then flushes the window with edge replication.
- Drives window shift/flush/bypass strobes and output coordinates for the datapath.

Parameters:
- IMAGE_W, 640, pixels per line; must be greater than HALF.
- IMAGE_H, 480, lines per frame.
- TAPS, 13, filter taps; odd, at least 3. HALF = (TAPS-1)/2 is a derived localparam.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&in_ready.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_type  in  4  low nibble of input data; packet type, sampled on sop beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_sop  out  1  output start of packet.
- out_eop  out  1  output end of packet.
- win_shift  out  1  datapath loads input pixel into the window.
- win_flush  out  1  datapath shifts the window using a replicated last pixel.
- bypass  out  1  datapath forwards raw input to output (header/control beats).
- x  out  11  column of the pixel currently on the output.
- y  out  11  row of the pixel currently on the output.
- frame_err  out  1  sticky; set on a short or long video frame.

Behaviour:
- Reset: state IDLE. All counters 0. All outputs 0, including frame_err. Reset mid-packet abandons the packet.
- Handshake: a beat is accepted on in_valid&in_ready and emitted on out_valid&out_ready.
- win_shift is high only on an accepted pixel beat. win_flush is high only on an emitted FLUSH beat. Both are combinational.
- Counters: acc = pixels accepted on the current line; emit = pixels emitted on the current line.
- IDLE:
  - in_ready=1. Beats without sop are discarded.
  - On an accepted sop beat: pass it through with bypass=1 and out_sop=1 (in_ready=out_ready, out_valid=in_valid).
  - in_type==0 goes to PRIME with y=0. Any other type goes to CTRL.
- CTRL:
  - Pure passthrough: bypass=1, in_ready=out_ready, out_valid=in_valid, out_eop=in_eop.
  - The accepted eop beat goes to IDLE.
- PRIME:
  - in_ready=1, out_valid=0.
  - When acc reaches HALF, go to STREAM.
- STREAM:
  - in_ready=out_ready, out_valid=in_valid. Each accepted pixel emits one pixel; x=emit.
  - On accepting the pixel with acc==IMAGE_W-1, go to FLUSH.
- FLUSH:
  - in_ready=0, out_valid=1. Emits exactly acc-emit beats; this is HALF for a normal line.
  - Line end: clear acc/emit, increment y, go to PRIME.
  - Last frame line (y==IMAGE_H-1): the final beat carries out_eop=1, then go to IDLE.
- Early eop (short frame):
  - Condition: in_eop on an accepted pixel before (IMAGE_W-1, IMAGE_H-1), in PRIME or STREAM.
  - Set frame_err and go to FLUSH. Flush only the outstanding acc-emit pixels; the last one carries out_eop.
  - If acc-emit is 0, assert out_eop on the pixel just emitted.
- Long frame:
  - Condition: the final pixel (IMAGE_W-1, IMAGE_H-1) is accepted without eop.
  - The frame completes normally with out_eop, then goes to DRAIN.
  - DRAIN: in_ready=1, out_valid=0. Set frame_err. Stay until an accepted eop beat, then go to IDLE.
- Simultaneous sop inside a video frame is treated as a pixel; it also sets frame_err.
- x/y hold their last value while out_valid=0. Width is 11 bits; IMAGE_W and IMAGE_H are at most 2047.

Optional Feature:
- BLUR_CTRL_FRAME_CNT_EN defined:
  - Adds output frame_count[15:0], reset 0.
  - Increments once per emitted video out_eop and wraps 65535->0.
  - Control packets and DRAIN do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use IMAGE_W=16, IMAGE_H=2, TAPS=13 (HALF=6).
- Nominal frame: sop(type 0) then 32 pixels, in_valid=out_ready=1, eop on the 32nd.
  -> Header emitted with out_sop.
  -> Per line: 6 cycles with out_valid=0, 10 streamed outputs, 6 win_flush outputs.
  -> 32 outputs total; out_eop at x=15,y=1; frame_err=0.
- Control packet: sop type 0xF, 3 beats, eop on beat 3.
  -> 3 bypass outputs, out_sop on beat 1, out_eop on beat 3, win_shift never asserted.
- Backpressure: nominal frame with out_ready toggling 1,0 each cycle.
  -> In STREAM, in_ready equals out_ready.
  -> Exactly 32 outputs, coordinates strictly sequential, none duplicated.
- Short frame: eop on pixel 20 (x=3,y=1, in PRIME).
  -> 4 flush outputs on line 1, out_eop on the 4th, 20 outputs total, frame_err=1, then IDLE.
- Long frame: 37 pixels, eop on the 37th.
  -> 32 outputs with out_eop on the 32nd; 5 beats accepted silently; frame_err=1; then IDLE.
- Reset mid-STREAM: assert reset at line 0, x=8.
  -> All outputs 0 immediately. After release, a new nominal frame produces 32 outputs; frame_err=0.
